// File: rtl/output_backprop.sv
// Backward-pass engine for the hidden-to-output layer: error, serial error x hidden
// products, learning-rate shift and saturating weight update. Optional: BACKPROP_ROUND_EN.
module output_backprop #(
   parameter int               HID_W    = 10,
   parameter int               FIN_W    = 23,
   parameter int               LR_SHIFT = 8,
   parameter logic signed [7:0] W0_INIT = 8'sd1,
   parameter logic signed [7:0] W1_INIT = 8'sd2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             zero_weight_reset_i,
   input  logic [FIN_W-1:0] final_i,
   input  logic [3:0]       target_i,
   input  logic [HID_W-1:0] hidden0_i,
   input  logic [HID_W-1:0] hidden1_i,
   input  logic [15:0]      w_init_i,
   output logic [15:0]      w_o,
   output logic             busy_o,
   output logic             b_end_o
);

   // Handshake: en_i is a level; a pass starts on its rising edge seen in IDLE,
   // and b_end_o pulses for exactly one cycle when both weights are written.

   localparam int ERR_W = 24;
   localparam int G_W   = 22;
   localparam int D_W   = 23;
   localparam int CNT_W = $clog2(HID_W + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_MUL0, S_UPD0, S_MUL1, S_UPD1, S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic                     en_q, en_d;
   logic [3:0]               target_q, target_d;
   logic [FIN_W-1:0]         final_q, final_d;
   logic [HID_W-1:0]         hid0_q, hid0_d;
   logic [HID_W-1:0]         hid1_q, hid1_d;
   logic [HID_W-1:0]         hsh_q, hsh_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [11:0]       err_q, err_d;
   logic signed [G_W-1:0]    acc_q, acc_d;
   logic signed [G_W-1:0]    mcand_q, mcand_d;
   logic signed [7:0]        w0_q, w0_d;
   logic signed [7:0]        w1_q, w1_d;

   logic                     start;
   logic signed [ERR_W-1:0]  err_full;
   logic signed [11:0]       err_sat;
   logic signed [D_W-1:0]    g_ext;
   logic signed [D_W-1:0]    delta;
   logic signed [7:0]        w_sel;
   logic signed [D_W-1:0]    w_sum;
   logic signed [7:0]        w_new;

   assign start = en_i & ~en_q & (state_q == S_IDLE);

   // Operands are zero-extended so the 24-bit difference cannot wrap.
   always_comb begin
      err_full = signed'({{(ERR_W-4){1'b0}}, target_q})
               - signed'({{(ERR_W-FIN_W){1'b0}}, final_q});
      if (err_full > 24'sd2047)
         err_sat = 12'sd2047;
      else if (err_full < -24'sd2048)
         err_sat = -12'sd2048;
      else
         err_sat = err_full[11:0];
   end

   always_comb begin
      g_ext = {acc_q[G_W-1], acc_q};
`ifdef BACKPROP_ROUND_EN
      delta = (g_ext + (23'sd1 <<< (LR_SHIFT - 1))) >>> LR_SHIFT;
`else
      delta = g_ext >>> LR_SHIFT;
`endif
      w_sel = (state_q == S_UPD0) ? w0_q : w1_q;
      w_sum = {{(D_W-8){w_sel[7]}}, w_sel} + delta;
      if (w_sum > 23'sd127)
         w_new = 8'sd127;
      else if (w_sum < -23'sd128)
         w_new = -8'sd128;
      else
         w_new = w_sum[7:0];
   end

   always_comb begin
      state_d  = state_q;
      en_d     = en_i;
      target_d = target_q;
      final_d  = final_q;
      hid0_d   = hid0_q;
      hid1_d   = hid1_q;
      hsh_d    = hsh_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      w0_d     = w0_q;
      w1_d     = w1_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = target_i;
               final_d  = final_i;
               hid0_d   = hidden0_i;
               hid1_d   = hidden1_i;
               state_d  = S_ERR;
            end
         end
         S_ERR: begin
            err_d   = err_sat;
            mcand_d = {{(G_W-12){err_sat[11]}}, err_sat};
            acc_d   = '0;
            hsh_d   = hid0_q;
            cnt_d   = '0;
            state_d = S_MUL0;
         end
         S_MUL0, S_MUL1: begin
            // One multiplier bit per cycle, LSB first, multiplicand walks left.
            if (hsh_q[0])
               acc_d = acc_q + mcand_q;
            mcand_d = mcand_q <<< 1;
            hsh_d   = hsh_q >> 1;
            if (cnt_q == CNT_W'(HID_W - 1)) begin
               cnt_d   = '0;
               state_d = (state_q == S_MUL0) ? S_UPD0 : S_UPD1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_UPD0: begin
            w0_d    = w_new;
            acc_d   = '0;
            mcand_d = {{(G_W-12){err_q[11]}}, err_q};
            hsh_d   = hid1_q;
            cnt_d   = '0;
            state_d = S_MUL1;
         end
         S_UPD1: begin
            w1_d    = w_new;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Weight reload wins over any pass, including one starting this cycle.
      if (zero_weight_reset_i) begin
         w0_d    = w_init_i[7:0];
         w1_d    = w_init_i[15:8];
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         en_q     <= 1'b0;
         target_q <= '0;
         final_q  <= '0;
         hid0_q   <= '0;
         hid1_q   <= '0;
         hsh_q    <= '0;
         cnt_q    <= '0;
         err_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         w0_q     <= W0_INIT;
         w1_q     <= W1_INIT;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         target_q <= target_d;
         final_q  <= final_d;
         hid0_q   <= hid0_d;
         hid1_q   <= hid1_d;
         hsh_q    <= hsh_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         w0_q     <= w0_d;
         w1_q     <= w1_d;
      end
   end

   assign w_o     = {w1_q, w0_q};
   assign busy_o  = (state_q != S_IDLE);
   assign b_end_o = (state_q == S_DONE);

endmodule

// File: tb/tb_output_backprop.sv
// Scoreboard bench for output_backprop: directed passes push expected weights,
// a monitor checks them on every b_end_o pulse.
module tb_output_backprop;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic        zero_weight_reset_i;
  logic [22:0] final_i;
  logic [3:0]  target_i;
  logic [9:0]  hidden0_i;
  logic [9:0]  hidden1_i;
  logic [15:0] w_init_i;
  logic [15:0] w_o;
  logic        busy_o;
  logic        b_end_o;

`ifdef BACKPROP_ROUND_EN
  localparam logic [15:0] POS1 = 16'h2A15;
  localparam logic [15:0] POS2 = 16'h5229;
`else
  localparam logic [15:0] POS1 = 16'h2915;
  localparam logic [15:0] POS2 = 16'h5029;
`endif

  logic [15:0] exp_q[$];
  int          start_q[$];
  int          cyc;
  int          n_pass;
  int          n_total;
  int          bend_cnt;

  output_backprop dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .en_i                (en_i),
    .zero_weight_reset_i (zero_weight_reset_i),
    .final_i             (final_i),
    .target_i            (target_i),
    .hidden0_i           (hidden0_i),
    .hidden1_i           (hidden1_i),
    .w_init_i            (w_init_i),
    .w_o                 (w_o),
    .busy_o              (busy_o),
    .b_end_o             (b_end_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor: every completion pulse must match the oldest expected pass
  always @(negedge clk_i) begin
    if (rst_i && b_end_o) begin
      bend_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_b_end", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        int          s;
        e = exp_q.pop_front();
        s = start_q.pop_front();
        check("w_at_b_end", {16'h0, w_o}, {16'h0, e});
        check("b_end_latency", cyc - s, 32'd23);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Returns at the negedge after start edge E0; inputs are scrambled afterwards.
  task automatic start_pass(input logic [3:0] t, input logic [22:0] f,
                            input logic [9:0] h0, input logic [9:0] h1,
                            input bit expect_done, input logic [15:0] exp_w);
    target_i  = t;
    final_i   = f;
    hidden0_i = h0;
    hidden1_i = h1;
    en_i      = 1'b1;
    if (expect_done) begin
      exp_q.push_back(exp_w);
      start_q.push_back(cyc + 1);
    end
    @(negedge clk_i);
    target_i  = 4'hF;
    final_i   = 23'd0;
    hidden0_i = 10'h3FF;
    hidden1_i = 10'h3FF;
  endtask

  task automatic run_to_done();
    int k;
    k = 0;
    while (!b_end_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check("pass_finished_in_time", {31'h0, (k < 40)}, 32'd1);
    @(negedge clk_i);
    check("busy_after_done", {31'h0, busy_o}, 32'd0);
    check("b_end_one_cycle", {31'h0, b_end_o}, 32'd0);
  endtask

  initial begin
    int b0;
    n_pass = 0;
    n_total = 0;
    bend_cnt = 0;
    rst_i = 1'b0;
    en_i = 1'b0;
    zero_weight_reset_i = 1'b0;
    final_i = '0;
    target_i = '0;
    hidden0_i = '0;
    hidden1_i = '0;
    w_init_i = '0;

    // reset state
    tick(3);
    check("reset_w", {16'h0, w_o}, 32'h0201);
    check("reset_busy", {31'h0, busy_o}, 32'd0);
    check("reset_b_end", {31'h0, b_end_o}, 32'd0);
    rst_i = 1'b1;
    tick(10);
    check("idle_w", {16'h0, w_o}, 32'h0201);
    check("idle_busy", {31'h0, busy_o}, 32'd0);

    // zero error: weights unchanged
    start_pass(4'd5, 23'd5, 10'd100, 10'd200, 1'b1, 16'h0201);
    check("zero_busy_after_start", {31'h0, busy_o}, 32'd1);
    run_to_done();
    en_i = 1'b0;
    tick(2);

    // positive error, with w0 update timing at E12
    start_pass(4'd15, 23'd5, 10'd512, 10'd1023, 1'b1, POS1);
    tick(11);
    check("w_before_e12", {16'h0, w_o}, 32'h0201);
    tick(1);
    check("w0_at_e12", {16'h0, w_o}, {16'h0, 8'h02, POS1[7:0]});
    run_to_done();
    en_i = 1'b0;
    tick(2);

    // reload weights; a start on the same edge is discarded
    w_init_i = 16'h0201;
    zero_weight_reset_i = 1'b1;
    en_i = 1'b1;
    tick(1);
    zero_weight_reset_i = 1'b0;
    check("reload_w", {16'h0, w_o}, 32'h0201);
    check("reload_start_discarded", {31'h0, busy_o}, 32'd0);
    tick(3);
    check("reload_held_en_no_pass", {31'h0, busy_o}, 32'd0);
    en_i = 1'b0;
    tick(2);

    // saturation
    start_pass(4'd0, 23'd100000, 10'd1023, 10'd0, 1'b1, 16'h0280);
    run_to_done();
    en_i = 1'b0;
    tick(2);

    // abort by weight reload at E5
    start_pass(4'd15, 23'd5, 10'd512, 10'd1023, 1'b0, 16'h0);
    tick(4);
    w_init_i = 16'h7F03;
    zero_weight_reset_i = 1'b1;
    tick(1);
    zero_weight_reset_i = 1'b0;
    en_i = 1'b0;
    check("abort_reload_w", {16'h0, w_o}, 32'h7F03);
    check("abort_reload_busy", {31'h0, busy_o}, 32'd0);
    tick(30);
    check("abort_reload_w_held", {16'h0, w_o}, 32'h7F03);

    // abort by async reset mid-pass
    start_pass(4'd15, 23'd5, 10'd512, 10'd1023, 1'b0, 16'h0);
    tick(14);
    rst_i = 1'b0;
    #1;
    check("abort_rst_w", {16'h0, w_o}, 32'h0201);
    check("abort_rst_busy", {31'h0, busy_o}, 32'd0);
    @(negedge clk_i);
    en_i = 1'b0;
    rst_i = 1'b1;
    tick(30);
    check("abort_rst_w_held", {16'h0, w_o}, 32'h0201);

    // re-arm: held en gives one pass, drop for one cycle gives another
    b0 = bend_cnt;
    start_pass(4'd15, 23'd5, 10'd512, 10'd1023, 1'b1, POS1);
    tick(60);
    check("held_en_single_pass", bend_cnt - b0, 32'd1);
    en_i = 1'b0;
    tick(1);
    start_pass(4'd15, 23'd5, 10'd512, 10'd1023, 1'b1, POS2);
    run_to_done();
    en_i = 1'b0;
    tick(5);
    check("rearm_total_passes", bend_cnt - b0, 32'd2);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
